// File: rtl/fft_input_loader.sv
// Buffers one N-point real frame in natural order and replays it bit-reversed to fft_architecture.
// Define FFT_LOADER_PINGPONG_EN to add a second bank so the next frame fills while the current one is consumed.
module fft_input_loader #(
    parameter int N      = 1024,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic              fft_ready_i,
    output logic              start_o,
    output logic [DATA_W-1:0] x0_re_o,
    output logic [DATA_W-1:0] x0_im_o,
    output logic [DATA_W-1:0] x1_re_o,
    output logic [DATA_W-1:0] x1_im_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    localparam int AW = $clog2(N);
`ifdef FFT_LOADER_PINGPONG_EN
    localparam int NB = 2;
    localparam int MW = AW + 1;
`else
    localparam int NB = 1;
    localparam int MW = AW;
`endif

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        STREAM     = 2'd1,
        WAIT_RDY   = 2'd2,
        WAIT_DRAIN = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     wp_reg, wp_next;
    logic [AW-1:0]     rp_reg, rp_next;
    logic [AW-1:0]     rd_idx;
    logic [MW-1:0]     wr_addr, rd_addr;
    logic [DATA_W-1:0] mem [0:NB*N-1];
    logic [DATA_W-1:0] rd_data_reg;
    logic              hs;
    logic              last_hs;

    assign hs      = s_valid_i && s_ready_o;
    assign last_hs = hs && (wp_reg == AW'(N - 1));
    assign wp_next = hs ? wp_reg + AW'(1) : wp_reg;

    // Read index is the stream counter with its bits mirrored.
    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_bitrev
            assign rd_idx[gi] = rp_reg[AW-1-gi];
        end
    endgenerate

`ifdef FFT_LOADER_PINGPONG_EN
    logic wr_bank_reg, wr_bank_next;
    logic rd_bank_reg, rd_bank_next;
    logic pend_full_reg, pend_full_next;

    assign s_ready_o = rstn && !pend_full_reg;
    assign wr_addr   = {wr_bank_reg, wp_reg};
    assign rd_addr   = {rd_bank_reg, rd_idx};

    // A bank completed outside FILL waits as pending; banks swap when streaming begins.
    always_comb begin
        wr_bank_next   = wr_bank_reg;
        rd_bank_next   = rd_bank_reg;
        pend_full_next = pend_full_reg;
        if (last_hs && state_reg != FILL)
            pend_full_next = 1'b1;
        if (state_next == STREAM && state_reg != STREAM) begin
            rd_bank_next   = wr_bank_reg;
            wr_bank_next   = ~wr_bank_reg;
            pend_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            pend_full_reg <= 1'b0;
        end else begin
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            pend_full_reg <= pend_full_next;
        end
    end
`else
    assign s_ready_o = rstn && (state_reg == FILL);
    assign wr_addr   = wp_reg;
    assign rd_addr   = rd_idx;
`endif

    always_comb begin
        state_next = state_reg;
        rp_next    = rp_reg;
        case (state_reg)
            FILL: begin
                if (last_hs)
                    state_next = STREAM;
            end
            STREAM: begin
                rp_next = rp_reg + AW'(1);
                if (rp_reg == AW'(N - 1))
                    state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (fft_ready_i)
                    state_next = WAIT_DRAIN;
            end
            WAIT_DRAIN: begin
                if (!fft_ready_i) begin
`ifdef FFT_LOADER_PINGPONG_EN
                    if (pend_full_reg || last_hs)
                        state_next = STREAM;
                    else
`endif
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= FILL;
            wp_reg    <= '0;
            rp_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wp_reg    <= wp_next;
            rp_reg    <= rp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (hs)
            mem[wr_addr] <= s_data_i;
    end

    // Output register only advances while streaming, so the last sample holds afterwards.
    always_ff @(posedge clk) begin
        if (!rstn)
            rd_data_reg <= '0;
        else if (state_reg == STREAM)
            rd_data_reg <= mem[rd_addr];
    end

    assign start_o = (state_reg == STREAM);
    assign busy_o  = (state_reg != FILL);
    assign state_o = state_reg;
    assign x0_re_o = rd_data_reg;
    assign x0_im_o = '0;
    assign x1_re_o = '0;
    assign x1_im_o = '0;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader at N=8: random frames checked against a bit-reversal reference model.
// Expectations adapt when FFT_LOADER_PINGPONG_EN is defined.
module tb_fft_input_loader;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int LOG2N = $clog2(N);
`ifdef FFT_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready_o;
    logic          fft_ready = 1'b0;
    logic          start_o;
    logic [DW-1:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;
    logic          busy_o;
    logic [1:0]    state_o;

    int vectors = 0;
    int miscompares = 0;

    fft_input_loader #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
        .fft_ready_i(fft_ready), .start_o(start_o),
        .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .x1_re_o(x1_re_o), .x1_im_o(x1_im_o),
        .busy_o(busy_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference: position k of the output frame carries input sample number bitrev(k).
    function automatic int bitrev(input int k);
        int r = 0;
        int t = k;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + t % 2;
            t = t / 2;
        end
        return r;
    endfunction

    task automatic do_reset();
        rstn = 1'b0; s_valid = 1'b0; fft_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // gap_mode: 0 back-to-back, 1 alternate valid 1,0,1,0, 2 random idle cycles.
    task automatic send_samples(input logic [DW-1:0] vals[$], input int gap_mode, output int timeouts);
        bit acc;
        int g;
        timeouts = 0;
        for (int i = 0; i < vals.size(); i++) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_data = vals[i];
            s_valid = 1'b1;
            acc = 1'b0;
            g = 0;
            while (!acc && g < 200) begin
                acc = (s_ready_o === 1'b1);
                @(negedge clk);
                g++;
            end
            if (!acc) timeouts++;
        end
        s_valid = 1'b0;
    endtask

    task automatic collect_frame(output logic [DW-1:0] got[$], output int wait_cyc,
                                 output int start_len, output int ready_hi, output int side_nz);
        got = {}; wait_cyc = 0; start_len = 0; ready_hi = 0; side_nz = 0;
        while (start_o !== 1'b1 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (start_o !== 1'b1) return;
        while (start_o === 1'b1 && start_len < 4 * N) begin
            if (s_ready_o === 1'b1) ready_hi++;
            @(negedge clk);
            start_len++;
            got.push_back(x0_re_o);
            if ((x0_im_o | x1_re_o | x1_im_o) !== '0) side_nz++;
        end
    endtask

    function automatic void make_expected(input logic [DW-1:0] vals[$], input int base,
                                          output logic [DW-1:0] exp_q[$]);
        exp_q = {};
        for (int k = 0; k < N; k++) exp_q.push_back(vals[base + bitrev(k)]);
    endfunction

    task automatic test_reset();
        rstn = 1'b0; s_valid = 1'b1; s_data = 32'hdead_beef; fft_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({start_o, busy_o, s_ready_o, state_o} !== 5'b0 || x0_re_o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got start=%b busy=%b ready=%b state=%0d x0=%0h exp all 0",
                     start_o, busy_o, s_ready_o, state_o, x0_re_o);
        end
        s_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready_o !== 1'b1 || state_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_release got ready=%b state=%0d exp ready=1 state=0", s_ready_o, state_o);
        end
        $display("test_reset: done");
    endtask

    task automatic check_frame(input string name, input logic [DW-1:0] got[$], input logic [DW-1:0] exp_q[$],
                               input int start_len, input int side_nz);
        vectors++;
        if (start_len != N || got.size() != N) begin
            miscompares++;
            $display("FAIL %s_start_len got %0d exp %0d", name, start_len, N);
        end
        for (int k = 0; k < N && k < got.size(); k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s_x0[%0d] got %0d exp %0d", name, k, got[k], exp_q[k]);
            end
        end
        vectors++;
        if (side_nz != 0) begin
            miscompares++;
            $display("FAIL %s_zero_outputs got %0d nonzero cycles exp 0", name, side_nz);
        end
    endtask

    task automatic test_bitrev_order();
        logic [DW-1:0] vals[$], got[$], exp_q[$];
        int to, wc, sl, rh, nz;
        do_reset();
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back(DW'(100 + i));
        send_samples(vals, 0, to);
        collect_frame(got, wc, sl, rh, nz);
        make_expected(vals, 0, exp_q);
        vectors++;
        if (to != 0 || wc != 0) begin
            miscompares++;
            $display("FAIL bitrev_entry got timeouts=%0d wait=%0d exp 0 0", to, wc);
        end
        check_frame("bitrev", got, exp_q, sl, nz);
        @(negedge clk);
        vectors++;
        if (x0_re_o !== exp_q[N-1]) begin
            miscompares++;
            $display("FAIL bitrev_hold got %0d exp %0d", x0_re_o, exp_q[N-1]);
        end
        $display("test_bitrev_order: frame of %0d samples, last=%0d", got.size(), x0_re_o);
    endtask

    task automatic test_stalled_input();
        logic [DW-1:0] vals[$], got[$], exp_q[$];
        int to, wc, sl, rh, nz;
        do_reset();
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back($urandom);
        send_samples(vals, 1, to);
        collect_frame(got, wc, sl, rh, nz);
        make_expected(vals, 0, exp_q);
        vectors++;
        if (to != 0 || wc != 0) begin
            miscompares++;
            $display("FAIL stall_entry got timeouts=%0d wait=%0d exp 0 0", to, wc);
        end
        check_frame("stall", got, exp_q, sl, nz);
        $display("test_stalled_input: frame collected, wait=%0d", wc);
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] vals[$], got[$], exp_q[$];
        int to, wc, sl, rh, nz;
        for (int f = 0; f < 3; f++) begin
            do_reset();
            vals = {};
            for (int i = 0; i < N; i++) vals.push_back($urandom);
            send_samples(vals, 2, to);
            collect_frame(got, wc, sl, rh, nz);
            make_expected(vals, 0, exp_q);
            vectors++;
            if (to != 0 || wc != 0) begin
                miscompares++;
                $display("FAIL random_entry got timeouts=%0d wait=%0d exp 0 0", to, wc);
            end
            check_frame("random", got, exp_q, sl, nz);
            $display("test_random_frames: frame %0d collected", f);
        end
    endtask

    task automatic test_fft_gating();
        logic [DW-1:0] vals[$], got[$];
        int to, wc, sl, rh, nz;
        do_reset();
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back($urandom);
        send_samples(vals, 0, to);
        collect_frame(got, wc, sl, rh, nz);
        for (int c = 0; c < 50; c++) begin
            vectors++;
            if (state_o !== 2'd2 || busy_o !== 1'b1 || s_ready_o !== PP) begin
                miscompares++;
                $display("FAIL gate_wait_rdy cycle %0d got state=%0d busy=%b ready=%b exp 2 1 %b",
                         c, state_o, busy_o, s_ready_o, PP);
            end
            @(negedge clk);
        end
        fft_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (state_o !== 2'd3 || busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL gate_wait_drain cycle %0d got state=%0d busy=%b exp 3 1", c, state_o, busy_o);
            end
        end
        fft_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd0 || busy_o !== 1'b0 || s_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL gate_fill got state=%0d busy=%b ready=%b exp 0 0 1", state_o, busy_o, s_ready_o);
        end
        $display("test_fft_gating: returned to state %0d", state_o);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals[$], got1[$], got2[$], exp1[$], exp2[$];
        int to, wc1, sl1, rh1, nz1, wc2, sl2, rh2, nz2;
        logic [1:0] st_rdy, st_after;
        logic rdy_wait;
        do_reset();
        vals = {};
        for (int i = 0; i < 2 * N; i++) vals.push_back($urandom);
        fork
            send_samples(vals, 0, to);
            begin
                collect_frame(got1, wc1, sl1, rh1, nz1);
                st_rdy = state_o;
                rdy_wait = s_ready_o;
                fft_ready = 1'b1;
                repeat (2) @(negedge clk);
                fft_ready = 1'b0;
                @(negedge clk);
                st_after = state_o;
                collect_frame(got2, wc2, sl2, rh2, nz2);
            end
        join
        make_expected(vals, 0, exp1);
        make_expected(vals, N, exp2);
        check_frame("b2b_frame1", got1, exp1, sl1, nz1);
        check_frame("b2b_frame2", got2, exp2, sl2, nz2);
        vectors++;
        if (rh1 != (PP ? N : 0)) begin
            miscompares++;
            $display("FAIL b2b_ready_in_stream got %0d exp %0d", rh1, PP ? N : 0);
        end
        vectors++;
        if (rdy_wait !== 1'b0 || st_rdy !== 2'd2) begin
            miscompares++;
            $display("FAIL b2b_wait_rdy got ready=%b state=%0d exp 0 2", rdy_wait, st_rdy);
        end
        vectors++;
        if (st_after !== (PP ? 2'd1 : 2'd0) || wc2 != (PP ? 0 : N) || to != 0) begin
            miscompares++;
            $display("FAIL b2b_after_drain got state=%0d wait=%0d timeouts=%0d exp %0d %0d 0",
                     st_after, wc2, to, PP ? 1 : 0, PP ? 0 : N);
        end
        $display("test_back_to_back: two frames, second wait=%0d", wc2);
    endtask

    task automatic test_reset_mid_fill();
        logic [DW-1:0] stale[$], vals[$], got[$], exp_q[$];
        int to, wc, sl, rh, nz;
        do_reset();
        stale = {};
        for (int i = 0; i < 5; i++) stale.push_back(DW'(900 + i));
        send_samples(stale, 0, to);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back(DW'(200 + i));
        send_samples(vals, 0, to);
        collect_frame(got, wc, sl, rh, nz);
        make_expected(vals, 0, exp_q);
        vectors++;
        if (to != 0 || wc != 0) begin
            miscompares++;
            $display("FAIL midfill_entry got timeouts=%0d wait=%0d exp 0 0", to, wc);
        end
        check_frame("midfill", got, exp_q, sl, nz);
        $display("test_reset_mid_fill: first=%0d", got.size() > 0 ? got[0] : 0);
    endtask

    task automatic test_reset_mid_stream();
        logic [DW-1:0] vals[$];
        int to, g;
        do_reset();
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back($urandom | 32'h1);
        send_samples(vals, 0, to);
        g = 0;
        while (start_o !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        vectors++;
        if (start_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_start got start=%b exp 1", start_o);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (start_o !== 1'b0 || x0_re_o !== '0 || state_o !== 2'd0 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset got start=%b x0=%0h state=%0d busy=%b ready=%b exp 0 0 0 0 0",
                     start_o, x0_re_o, state_o, busy_o, s_ready_o);
        end
        rstn = 1'b1;
        @(negedge clk);
        $display("test_reset_mid_stream: state after release %0d", state_o);
    endtask

    initial begin
        test_reset();
        test_bitrev_order();
        test_stalled_input();
        test_random_frames();
        test_fft_gating();
        test_back_to_back();
        test_reset_mid_fill();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
